// File: rtl/sampling_pkg.sv
// Shared types and helpers for the adaptive sampling path.
package sampling_pkg;

    localparam int DATA_W = 14;
    localparam int TGT_W  = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ACCUM  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    function automatic logic [31:0] clamp(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/abs_diff_accum.sv
// Windowed sum of absolute sample-to-sample differences; owns prev, acc and cnt.
module abs_diff_accum #(
    parameter int DATA_W   = 14,
    parameter int WIN_LOG2 = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_prime,
    input  logic                       i_accum,
    input  logic [DATA_W-1:0]          i_data,
    output logic [DATA_W+WIN_LOG2-1:0] o_acc,
    output logic                       o_window_last
);

    logic [DATA_W-1:0]          r_prev;
    logic [DATA_W+WIN_LOG2-1:0] r_acc;
    logic [WIN_LOG2-1:0]        r_cnt;
    logic [DATA_W-1:0]          w_diff;

    assign w_diff        = (i_data >= r_prev) ? (i_data - r_prev) : (r_prev - i_data);
    assign o_window_last = i_accum && (r_cnt == {WIN_LOG2{1'b1}});
    assign o_acc         = r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (i_accum) begin
                r_acc <= r_acc + {{WIN_LOG2{1'b0}}, w_diff};
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_prime || (i_accum && !i_clear))
                r_prev <= i_data;
        end
    end

endmodule

// File: rtl/sample_rate_ctrl.sv
// Maps window activity to a clamped capture sample count, applied on capture_done.
// Optional: define SAMPLE_RATE_HYST_EN to stage only changes larger than HYST.
module sample_rate_ctrl
    import sampling_pkg::*;
#(
    parameter int DATA_W    = sampling_pkg::DATA_W,
    parameter int TGT_W     = sampling_pkg::TGT_W,
    parameter int WIN_LOG2  = 6,
    parameter int ACT_SHIFT = 6,
    parameter int TGT_MIN   = 16,
    parameter int TGT_MAX   = 1000
`ifdef SAMPLE_RATE_HYST_EN
    ,parameter int HYST     = 8
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       data_valid,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       capture_done,
    output logic [TGT_W-1:0]           sample_target,
    output logic                       target_pending,
    output logic [DATA_W+WIN_LOG2-1:0] activity
);

    state_t                     r_state, w_next;
    logic                       w_clear, w_prime, w_accum, w_update, w_stage_ok;
    logic                       w_window_last;
    logic [DATA_W+WIN_LOG2-1:0] w_acc;
    logic [31:0]                w_sum;
    logic [TGT_W-1:0]           w_new;
    logic [TGT_W-1:0]           r_staged, r_target;
    logic                       r_pending;
    logic [DATA_W+WIN_LOG2-1:0] r_activity;

    abs_diff_accum #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) u_accum (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_prime       (w_prime),
        .i_accum       (w_accum),
        .i_data        (data_in),
        .o_acc         (w_acc),
        .o_window_last (w_window_last)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!enable) w_next = IDLE;
        else begin
            case (r_state)
                IDLE:    w_next = PRIME;
                PRIME:   if (data_valid) w_next = ACCUM;
                ACCUM:   if (w_window_last) w_next = UPDATE;
                UPDATE:  w_next = ACCUM;
                default: w_next = IDLE;
            endcase
        end
    end

    // Valids in UPDATE are dropped: neither accumulated nor taken as prev.
    always_comb begin
        w_prime  = 1'b0;
        w_accum  = 1'b0;
        w_update = 1'b0;
        w_clear  = !enable;
        if (enable) begin
            w_prime  = (r_state == PRIME) && data_valid;
            w_accum  = (r_state == ACCUM) && data_valid;
            w_update = (r_state == UPDATE);
            w_clear  = (r_state == UPDATE);
        end
    end

    assign w_sum = 32'(TGT_MIN) + 32'(w_acc >> ACT_SHIFT);
    assign w_new = TGT_W'(clamp(w_sum, 32'(TGT_MIN), 32'(TGT_MAX)));

`ifdef SAMPLE_RATE_HYST_EN
    logic [TGT_W-1:0] w_delta;
    assign w_delta    = (w_new >= r_target) ? (w_new - r_target) : (r_target - w_new);
    assign w_stage_ok = (32'(w_delta) > 32'(HYST));
`else
    assign w_stage_ok = 1'b1;
`endif

    // A same-cycle UPDATE re-arms pending after the apply has consumed the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target   <= TGT_W'(TGT_MIN);
            r_staged   <= '0;
            r_pending  <= 1'b0;
            r_activity <= '0;
        end else begin
            if (r_pending && capture_done) begin
                r_target  <= r_staged;
                r_pending <= 1'b0;
            end
            if (w_update) begin
                r_activity <= w_acc;
                if (w_stage_ok) begin
                    r_staged  <= w_new;
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign sample_target  = r_target;
    assign target_pending = r_pending;
    assign activity       = r_activity;

endmodule

// File: tb/tb_sample_rate_ctrl.sv
// Directed self-checking bench for sample_rate_ctrl (default build).
module tb_sample_rate_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        data_valid = 1'b0;
    logic [13:0] data_in = '0;
    logic        capture_done = 1'b0;
    logic [9:0]  sample_target;
    logic        target_pending;
    logic [19:0] activity;

    int n_checks = 0;
    int n_fail   = 0;

    sample_rate_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .data_valid     (data_valid),
        .data_in        (data_in),
        .capture_done   (capture_done),
        .sample_target  (sample_target),
        .target_pending (target_pending),
        .activity       (activity)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [13:0] v);
        data_in    = v;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic send_alt(input int n, input logic [13:0] a, input logic [13:0] b);
        for (int i = 0; i < n; i++) send((i % 2) ? b : a);
    endtask

    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    task automatic done_pulse();
        capture_done = 1'b1;
        tick();
        capture_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (sample_target !== 10'd16) begin
            $display("FAIL reset_target: got %0d want 16", sample_target); n_fail++;
        end
        n_checks++;
        if (target_pending !== 1'b0) begin
            $display("FAIL reset_pending: got %0b want 0", target_pending); n_fail++;
        end
        n_checks++;
        if (activity !== 20'd0) begin
            $display("FAIL reset_activity: got %0d want 0", activity); n_fail++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_constant();
        restart();
        for (int i = 0; i < 65; i++) send(14'h1000);
        tick();
        n_checks++;
        if (activity !== 20'd0 || target_pending !== 1'b1) begin
            $display("FAIL const_window: activity %0d pending %0b want 0/1", activity, target_pending); n_fail++;
        end
        done_pulse();
        n_checks++;
        if (sample_target !== 10'd16 || target_pending !== 1'b0) begin
            $display("FAIL const_apply: target %0d pending %0b want 16/0", sample_target, target_pending); n_fail++;
        end
        done_pulse();
        n_checks++;
        if (sample_target !== 10'd16 || target_pending !== 1'b0) begin
            $display("FAIL done_no_pending: target %0d pending %0b want 16/0", sample_target, target_pending); n_fail++;
        end
    endtask

    task automatic test_step();
        restart();
        send_alt(65, 14'd0, 14'd100);
        n_checks++;
        if (target_pending !== 1'b0) begin
            $display("FAIL step_latency: pending %0b want 0 in UPDATE cycle", target_pending); n_fail++;
        end
        tick();
        n_checks++;
        if (activity !== 20'd6400 || target_pending !== 1'b1) begin
            $display("FAIL step_window: activity %0d pending %0b want 6400/1", activity, target_pending); n_fail++;
        end
        capture_done = 1'b1;
        #1;
        n_checks++;
        if (sample_target !== 10'd16) begin
            $display("FAIL step_before_apply: target %0d want 16", sample_target); n_fail++;
        end
        tick();
        capture_done = 1'b0;
        n_checks++;
        if (sample_target !== 10'd116 || target_pending !== 1'b0) begin
            $display("FAIL step_apply: target %0d pending %0b want 116/0", sample_target, target_pending); n_fail++;
        end
    endtask

    task automatic test_clamp_max();
        restart();
        send_alt(65, 14'd0, 14'd16383);
        tick();
        n_checks++;
        if (activity !== 20'd1048512) begin
            $display("FAIL clamp_activity: got %0d want 1048512", activity); n_fail++;
        end
        done_pulse();
        n_checks++;
        if (sample_target !== 10'd1000) begin
            $display("FAIL clamp_target: got %0d want 1000", sample_target); n_fail++;
        end
    endtask

    task automatic test_latest_wins();
        restart();
        send_alt(65, 14'd0, 14'd100);
        tick();
        send_alt(64, 14'd50, 14'd0);
        tick();
        n_checks++;
        if (activity !== 20'd3200 || target_pending !== 1'b1 || sample_target !== 10'd1000) begin
            $display("FAIL latest_window: activity %0d pending %0b target %0d want 3200/1/1000",
                     activity, target_pending, sample_target); n_fail++;
        end
        done_pulse();
        n_checks++;
        if (sample_target !== 10'd66 || target_pending !== 1'b0) begin
            $display("FAIL latest_apply: target %0d pending %0b want 66/0", sample_target, target_pending); n_fail++;
        end
    endtask

    task automatic test_enable_drop();
        restart();
        send_alt(30, 14'd0, 14'd100);
        enable = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (activity !== 20'd3200 || target_pending !== 1'b0) begin
            $display("FAIL drop_partial: activity %0d pending %0b want 3200/0", activity, target_pending); n_fail++;
        end
        enable = 1'b1;
        tick();
        send_alt(65, 14'd0, 14'd20);
        tick();
        n_checks++;
        if (activity !== 20'd1280 || target_pending !== 1'b1) begin
            $display("FAIL drop_next_window: activity %0d pending %0b want 1280/1", activity, target_pending); n_fail++;
        end
        done_pulse();
        n_checks++;
        if (sample_target !== 10'd36) begin
            $display("FAIL drop_apply: target %0d want 36", sample_target); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        restart();
        send_alt(65, 14'd0, 14'd100);
        tick();
        send_alt(64, 14'd50, 14'd0);
        capture_done = 1'b1;
        tick();
        capture_done = 1'b0;
        n_checks++;
        if (sample_target !== 10'd116 || target_pending !== 1'b1 || activity !== 20'd3200) begin
            $display("FAIL simul_update_apply: target %0d pending %0b activity %0d want 116/1/3200",
                     sample_target, target_pending, activity); n_fail++;
        end
        done_pulse();
        n_checks++;
        if (sample_target !== 10'd66 || target_pending !== 1'b0) begin
            $display("FAIL simul_second_apply: target %0d pending %0b want 66/0", sample_target, target_pending); n_fail++;
        end
    endtask

    task automatic test_reset_mid_window();
        restart();
        send_alt(65, 14'd0, 14'd100);
        tick();
        send_alt(20, 14'd0, 14'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (sample_target !== 10'd16 || target_pending !== 1'b0 || activity !== 20'd0) begin
            $display("FAIL reset_mid: target %0d pending %0b activity %0d want 16/0/0",
                     sample_target, target_pending, activity); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_step();
        test_clamp_max();
        test_latest_wins();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
